// File: rtl/usb_bit_stuffer_if.sv
// +------------------------------------------------------------------+
// | usb_bit_stuffer_if : upstream/downstream bit-stream handshake      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface usb_bit_stuffer_if;
  logic in_bit;
  logic in_last;
  logic in_valid;
  logic in_ready;
  logic out_bit;
  logic out_last;
  logic out_stuffed;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_bit, in_last, in_valid, out_ready,
    input  in_ready, out_bit, out_last, out_stuffed, out_valid
  );

  modport slave (
    input  in_bit, in_last, in_valid, out_ready,
    output in_ready, out_bit, out_last, out_stuffed, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/usb_bit_stuffer.sv
// +------------------------------------------------------------------+
// | usb_bit_stuffer : FIFO-buffered USB bit stuffer, optional NRZI     |
// | Optional feature macro: USB_NRZI_EN                              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module usb_bit_stuffer #(
  parameter int RUN_LEN = 6,
  parameter int DEPTH   = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  usb_bit_stuffer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0]       c_st_pass  = 1'b0;
  localparam logic [0:0]       c_st_stuff = 1'b1;
  localparam logic [3:0]       c_run_len  = 4'(RUN_LEN);
  localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);

  // Each entry holds {bit, last}
  logic [1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [0:0]       state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic             pend_last_q, pend_last_d;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_fire;
  logic [1:0] w_head;
  logic [3:0] w_run_inc;
  logic       w_trig;
  logic       w_logic;
  logic       w_valid;
  logic       w_last;

  assign w_full    = (cnt_q == c_depth);
  assign w_empty   = (cnt_q == '0);
  assign w_head    = mem_q[rd_ptr_q];
  assign w_run_inc = run_q + 4'd1;
  assign w_push    = bus.in_valid & ~w_full;

  // A data 1 that completes the run defers its last flag to the stuff beat
  assign w_trig  = (state_q == c_st_pass) & ~w_empty & w_head[1] & (w_run_inc == c_run_len);
  assign w_valid = (state_q == c_st_pass) ? ~w_empty : 1'b1;
  assign w_logic = (state_q == c_st_pass) & ~w_empty & w_head[1];
  assign w_last  = (state_q == c_st_pass) ? (~w_empty & w_head[0] & ~w_trig) : pend_last_q;
  assign w_fire  = w_valid & bus.out_ready;
  assign w_pop   = w_fire & (state_q == c_st_pass);

  assign bus.in_ready    = ~w_full;
  assign bus.out_valid   = w_valid;
  assign bus.out_last    = w_last;
  assign bus.out_stuffed = (state_q == c_st_stuff);

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    pend_last_d = pend_last_q;
    if (w_fire) begin
      if (state_q == c_st_stuff) begin
        state_d     = c_st_pass;
        run_d       = 4'd0;
        pend_last_d = 1'b0;
      end else if (w_logic) begin
        if (w_trig) begin
          state_d     = c_st_stuff;
          run_d       = w_run_inc;
          pend_last_d = w_head[0];
        end else if (w_head[0]) begin
          run_d = 4'd0;
        end else begin
          run_d = w_run_inc;
        end
      end else begin
        run_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {bus.in_bit, bus.in_last};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= c_st_pass;
      run_q       <= 4'd0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      pend_last_q <= pend_last_d;
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (w_push && !w_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!w_push && w_pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

`ifdef USB_NRZI_EN
  logic level_q;
  logic w_level_next;

  // Line level after this beat: a 0 toggles, a 1 holds
  assign w_level_next = w_logic ? level_q : ~level_q;
  assign bus.out_bit  = w_valid ? w_level_next : level_q;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      level_q <= 1'b1;
    end else if (w_fire) begin
      level_q <= w_last ? 1'b1 : w_level_next;
    end
  end
`else
  assign bus.out_bit = w_logic;
`endif

endmodule

`default_nettype wire

// File: tb/tb_usb_bit_stuffer.sv
// +------------------------------------------------------------------+
// | tb_usb_bit_stuffer : directed + random checks vs stream model     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_usb_bit_stuffer;

  localparam int RUN_LEN = 6;
  localparam int DEPTH   = 16;

  logic clk = 1'b0;
  logic rst_b;

  always #5 clk = ~clk;

  usb_bit_stuffer_if bus ();

  usb_bit_stuffer #(.RUN_LEN(RUN_LEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Expected output beats {bit, last, stuffed}, derived from accepted input
  logic [2:0] exp_q[$];
  int         occ;
  int         run;
  logic       lvl;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, expv);
    end
  endtask

  function automatic void model_push(input logic b, input logic l);
    occ++;
    if (b) begin
      run++;
      if (run == RUN_LEN) begin
        exp_q.push_back({1'b1, 1'b0, 1'b0});
        exp_q.push_back({1'b0, l, 1'b1});
        run = 0;
      end else begin
        exp_q.push_back({1'b1, l, 1'b0});
        if (l) run = 0;
      end
    end else begin
      exp_q.push_back({1'b0, l, 1'b0});
      run = 0;
    end
  endfunction

  task automatic step();
    logic [2:0] h;
    logic       ebit;
    @(negedge clk);
    if (rst_b) begin
      exp_q.delete();
      occ = 0;
      run = 0;
      lvl = 1'b1;
    end else begin
      check_val("in_ready", bus.in_ready, occ != DEPTH);
      check_val("out_valid", bus.out_valid, exp_q.size() != 0);
      if (bus.out_valid && exp_q.size() != 0) begin
        h    = exp_q[0];
        ebit = h[2];
`ifdef USB_NRZI_EN
        ebit = h[2] ? lvl : ~lvl;
`endif
        check_val("out_bit", bus.out_bit, ebit);
        check_val("out_last", bus.out_last, h[1]);
        check_val("out_stuffed", bus.out_stuffed, h[0]);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          if (!h[0]) occ--;
          lvl = h[1] ? 1'b1 : ebit;
        end
      end
      if (bus.in_valid && bus.in_ready) model_push(bus.in_bit, bus.in_last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic [31:0] bits);
    logic acc;
    int   waited;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = bits[i];
      bus.in_last  = (i == n - 1);
      waited = 0;
      do begin
        acc = bus.in_ready;
        step();
        waited++;
      end while (!acc && waited < 200);
      if (!acc) check_val("send_timeout", 32'd0, 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      step();
      n++;
    end
    check_val("drain", exp_q.size(), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_valid"}, bus.out_valid, 1'b0);
    check_val({tag, "_last"}, bus.out_last, 1'b0);
    check_val({tag, "_stuffed"}, bus.out_stuffed, 1'b0);
    check_val({tag, "_in_ready"}, bus.in_ready, 1'b1);
`ifdef USB_NRZI_EN
    check_val({tag, "_bit"}, bus.out_bit, 1'b1);
`else
    check_val({tag, "_bit"}, bus.out_bit, 1'b0);
`endif
  endtask

  initial begin
    bus.in_bit    = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_b         = 1'b1;
    occ = 0;
    run = 0;
    lvl = 1'b1;
    step();
    step();
    rst_b = 1'b0;
    check_idle("reset");

    // 7 ones: stuff after the 6th, last stays on the trailing data 1
    bus.out_ready = 1'b1;
    send(7, 32'h7F);
    drain();

    // 6 ones with last on the 6th: last moves to the stuff beat
    send(6, 32'h3F);
    drain();

    // Fill with backpressure, 17th beat waits until one pop
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_bit  = i[0];
      bus.in_last = 1'b0;
      step();
    end
    check_val("full_in_ready", bus.in_ready, 1'b0);
    bus.in_bit  = 1'b1;
    bus.in_last = 1'b1;
    repeat (3) step();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_val("reopen_in_ready", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    drain();

    // Backpressure while the stuff beat is presented
    bus.out_ready = 1'b0;
    send(7, 32'h3F);
    bus.out_ready = 1'b1;
    repeat (6) step();
    bus.out_ready = 1'b0;
    check_val("stuff_presented", bus.out_stuffed, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'($urandom_range(0, 1));
      bus.in_last  = 1'b0;
      step();
      check_val("stuff_hold", bus.out_stuffed, 1'b1);
    end
    bus.in_last = 1'b1;
    step();
    drain();

    // NRZI pattern 0 1 0 0 (last)
    send(4, 32'h2);
    drain();
    check_idle("after_last");

    // Reset mid-run after 4 queued ones
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_bit    = 1'b1;
    repeat (4) step();
    bus.in_valid = 1'b0;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    check_idle("midrst");
    bus.out_ready = 1'b1;
    send(7, 32'h7F);
    drain();

    // Randomized traffic biased toward long runs of ones
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_bit    = ($urandom_range(0, 3) != 0);
      bus.in_last   = ($urandom_range(0, 11) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (c == 1500) rst_b = 1'b1;
      step();
      rst_b = 1'b0;
    end
    bus.in_last = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
